// File: rtl/priority_encoder_stream.sv
// rtl/priority_encoder_stream.sv - streams the indices of the set bits of each accepted vector, one beat per cycle
module priority_encoder_stream #(
  parameter int WIDTH = 16,
  parameter int SPLIT = 4,
  parameter bit MSB_FIRST = 1'b0,
  localparam int WIDTH_LOG = $clog2(WIDTH)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_vld,
  output logic                 in_rdy,
  input  logic [WIDTH-1:0]     in_dat,
  output logic                 out_vld,
  input  logic                 out_rdy,
  output logic [WIDTH_LOG-1:0] out_idx,
  output logic                 out_lst,
  output logic                 out_emp
);

  localparam int NGRP = (WIDTH + SPLIT - 1) / SPLIT;
  localparam int PADW = NGRP * SPLIT;

  typedef enum logic [1:0] {IDLE, SCAN, ZERO} state_t;

  state_t               state, state_nxt;
  logic [WIDTH-1:0]     mask, mask_nxt;
  logic [WIDTH-1:0]     scan_vec;
  logic [PADW-1:0]      padded;
  logic [NGRP-1:0]      grp_any;
  logic [SPLIT-1:0]     grp_bits;
  int                   grp_sel;
  int                   bit_sel;
  logic [WIDTH_LOG-1:0] enc_idx;
  logic                 single;
  logic                 out_fire;
  logic                 in_acc;

  // Reversing the mask for MSB-first lets one lowest-set-bit encoder serve both orders.
  always_comb begin
    for (int i = 0; i < WIDTH; i++) begin
      scan_vec[i] = MSB_FIRST ? mask[WIDTH-1-i] : mask[i];
    end
  end

  always_comb begin
    padded = '0;
    padded[WIDTH-1:0] = scan_vec;
  end

  for (genvar g = 0; g < NGRP; g++) begin : g_grp
    assign grp_any[g] = |padded[g*SPLIT +: SPLIT];
  end

  // Two-level tree: first non-empty group of SPLIT bits, then first set bit inside it.
  always_comb begin
    grp_sel = 0;
    for (int g = NGRP - 1; g >= 0; g--) begin
      if (grp_any[g]) grp_sel = g;
    end
    grp_bits = padded[grp_sel*SPLIT +: SPLIT];
    bit_sel = 0;
    for (int b = SPLIT - 1; b >= 0; b--) begin
      if (grp_bits[b]) bit_sel = b;
    end
  end

  assign enc_idx = WIDTH_LOG'(MSB_FIRST ? (WIDTH - 1 - (grp_sel * SPLIT + bit_sel))
                                        : (grp_sel * SPLIT + bit_sel));
  assign single  = (mask != '0) && ((mask & (mask - WIDTH'(1))) == '0);

  assign out_vld  = (state != IDLE);
  assign out_emp  = (state == ZERO);
  assign out_lst  = ((state == SCAN) && single) || (state == ZERO);
  assign out_idx  = (state == SCAN) ? enc_idx : '0;
  assign out_fire = out_vld & out_rdy;
  assign in_rdy   = !rst && ((state == IDLE) || (out_fire && out_lst));
  assign in_acc   = in_vld & in_rdy;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      mask  <= '0;
    end else begin
      state <= state_nxt;
      mask  <= mask_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    mask_nxt  = mask;
    case (state)
      IDLE: ;
      SCAN: begin
        if (out_fire) begin
          if (out_lst) begin
            state_nxt = IDLE;
            mask_nxt  = '0;
          end else begin
            mask_nxt = mask & ~(WIDTH'(1) << enc_idx);
          end
        end
      end
      ZERO: begin
        if (out_fire) state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
        mask_nxt  = '0;
      end
    endcase
    // A new vector can only be accepted when idle or as the final beat leaves.
    if (in_acc) begin
      if (in_dat != '0) begin
        state_nxt = SCAN;
        mask_nxt  = in_dat;
      end else begin
        state_nxt = ZERO;
        mask_nxt  = '0;
      end
    end
  end

endmodule

// File: tb/tb_priority_encoder_stream.sv
// tb/tb_priority_encoder_stream.sv - checks both emission orders against a queue-of-beats reference model
module tb_priority_encoder_stream;

  logic        clk = 1'b0;
  logic        rst, in_vld, out_rdy;
  logic [15:0] in_dat;
  logic        in_rdy_a, out_vld_a, out_lst_a, out_emp_a;
  logic [3:0]  out_idx_a;
  logic        in_rdy_b, out_vld_b, out_lst_b, out_emp_b;
  logic [3:0]  out_idx_b;

  int n_vec = 0;
  int n_err = 0;
  // Remaining beats of the vector in flight: bits [3:0] idx, [8] last, [9] empty.
  int qa[$];
  int qb[$];

  always #5 clk = ~clk;

  priority_encoder_stream #(.WIDTH(16), .SPLIT(4), .MSB_FIRST(1'b0)) u_lsb (
    .clk(clk), .rst(rst), .in_vld(in_vld), .in_rdy(in_rdy_a), .in_dat(in_dat),
    .out_vld(out_vld_a), .out_rdy(out_rdy), .out_idx(out_idx_a),
    .out_lst(out_lst_a), .out_emp(out_emp_a)
  );

  priority_encoder_stream #(.WIDTH(16), .SPLIT(4), .MSB_FIRST(1'b1)) u_msb (
    .clk(clk), .rst(rst), .in_vld(in_vld), .in_rdy(in_rdy_b), .in_dat(in_dat),
    .out_vld(out_vld_b), .out_rdy(out_rdy), .out_idx(out_idx_b),
    .out_lst(out_lst_b), .out_emp(out_emp_b)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic void load(input logic [15:0] d);
    int set_bits[$];
    if (d == 16'h0) begin
      qa.push_back(32'h300);
      qb.push_back(32'h300);
    end else begin
      for (int i = 0; i < 16; i++) if (d[i]) set_bits.push_back(i);
      for (int k = 0; k < set_bits.size(); k++) begin
        qa.push_back(set_bits[k] | ((k == set_bits.size() - 1) ? 32'h100 : 0));
        qb.push_back(set_bits[set_bits.size() - 1 - k] | ((k == set_bits.size() - 1) ? 32'h100 : 0));
      end
    end
  endfunction

  task automatic check_inst(input string nm, input int q[$], input logic vld, input logic rdy,
                            input logic [3:0] idx, input logic lst, input logic emp, input bit exp_rdy);
    int b;
    b = (q.size() > 0) ? q[0] : 0;
    chk({nm, ".in_rdy"}, rdy, exp_rdy);
    chk({nm, ".out_vld"}, vld, q.size() > 0);
    chk({nm, ".out_idx"}, idx, b[3:0]);
    chk({nm, ".out_lst"}, lst, b[8]);
    chk({nm, ".out_emp"}, emp, b[9]);
  endtask

  // Inputs change 1 time unit after the rising edge; outputs are sampled mid-cycle.
  task automatic cycle(input bit r, input bit v, input logic [15:0] d, input bit o, output bit acc);
    bit exp_rdy;
    rst = r; in_vld = v; in_dat = d; out_rdy = o;
    #3;
    exp_rdy = !r && (qa.size() == 0 || (o && qa.size() == 1));
    check_inst("lsb", qa, out_vld_a, in_rdy_a, out_idx_a, out_lst_a, out_emp_a, exp_rdy);
    check_inst("msb", qb, out_vld_b, in_rdy_b, out_idx_b, out_lst_b, out_emp_b, exp_rdy);
    acc = v && exp_rdy;
    if (r) begin
      qa.delete();
      qb.delete();
    end else begin
      if (o && qa.size() > 0) begin
        void'(qa.pop_front());
        void'(qb.pop_front());
      end
      if (acc) load(d);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n, input bit o);
    bit acc;
    for (int i = 0; i < n; i++) cycle(1'b0, 1'b0, 16'h0, o, acc);
  endtask

  task automatic push(input logic [15:0] d, input bit o);
    bit acc;
    acc = 1'b0;
    for (int i = 0; i < 40 && !acc; i++) cycle(1'b0, 1'b1, d, o, acc);
    if (!acc) chk("push_timeout", 0, 1);
  endtask

  initial begin
    bit acc;
    rst = 1'b1; in_vld = 1'b0; in_dat = '0; out_rdy = 1'b0;
    @(posedge clk);
    #1;
    cycle(1'b1, 1'b1, 16'h1234, 1'b1, acc);
    cycle(1'b1, 1'b0, 16'h0, 1'b0, acc);

    push(16'h8421, 1'b1);
    chk("first_beat_idx", out_idx_a, 4'd0);
    idle(5, 1'b1);

    push(16'h0000, 1'b1);
    idle(2, 1'b1);

    push(16'h0003, 1'b1);
    push(16'h8000, 1'b1);
    idle(3, 1'b1);

    push(16'h0006, 1'b1);
    for (int i = 0; i < 3; i++) cycle(1'b0, 1'b0, 16'h0, 1'b0, acc);
    idle(3, 1'b1);

    push(16'hFFFF, 1'b1);
    idle(5, 1'b1);
    cycle(1'b1, 1'b0, 16'h0, 1'b1, acc);
    push(16'h0010, 1'b1);
    idle(3, 1'b1);

    push(16'hFFFF, 1'b1);
    idle(18, 1'b1);

    push(16'h00F0, 1'b0);
    cycle(1'b0, 1'b0, 16'h0, 1'b0, acc);
    cycle(1'b1, 1'b0, 16'h0, 1'b0, acc);
    idle(2, 1'b1);

    for (int i = 0; i < 600; i++) begin
      logic [15:0] d;
      case ($urandom_range(0, 3))
        0: d = 16'h0;
        1: d = 16'(1) << $urandom_range(0, 15);
        2: d = 16'($urandom);
        default: d = 16'($urandom & $urandom);
      endcase
      cycle($urandom_range(0, 59) == 0, $urandom_range(0, 2) != 0, d,
            $urandom_range(0, 3) != 0, acc);
    end
    idle(20, 1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/priority_encoder_stream.md
PRIORITY_ENCODER_STREAM -- requirements
Module: priority_encoder_stream

Interface
REQ-001 SHALL have parameter WIDTH, default 16: input vector width, any value >= 2.
REQ-002 SHALL have parameter SPLIT, default 4: tree split factor of the internal combinational priority encoder.
REQ-003 SHALL have parameter MSB_FIRST, default 0: 0 emits set bits lowest index first, 1 emits highest index first.
REQ-004 SHALL have localparam WIDTH_LOG = $clog2(WIDTH).
REQ-005 SHALL have port clk  input  1: clock; all state updates on rising edge.
REQ-006 SHALL have port rst  input  1: reset, synchronous, active-high.
REQ-007 SHALL have port in_vld  input  1: input vector valid.
REQ-008 SHALL have port in_rdy  output  1: block accepts input vector.
REQ-009 SHALL have port in_dat  input  WIDTH: vector to enumerate.
REQ-010 SHALL have port out_vld  output  1: output beat valid.
REQ-011 SHALL have port out_rdy  input  1: consumer accepts output beat.
REQ-012 SHALL have port out_idx  output  WIDTH_LOG: index of current set bit.
REQ-013 SHALL have port out_lst  output  1: current beat is last for this vector.
REQ-014 SHALL have port out_emp  output  1: input vector was all zeros, no index.

Function
REQ-015 SHALL implement states IDLE, SCAN, ZERO, held in a state register with a WIDTH-bit mask register.
REQ-016 Handshake: transfer occurs on a cycle where vld and rdy are both high; in_rdy SHALL NOT depend on in_vld; out_vld SHALL NOT depend on out_rdy.
REQ-017 IDLE: in_rdy=1, out_vld=0; on input transfer with in_dat!=0, mask<=in_dat, go SCAN; with in_dat==0, go ZERO.
REQ-018 Latency: first output beat valid exactly one cycle after the input transfer.
REQ-019 SCAN: out_vld=1; out_idx = lowest (MSB_FIRST=0) or highest (MSB_FIRST=1) set bit of mask; out_emp=0.
REQ-020 SCAN: out_lst=1 iff mask has exactly one bit set.
REQ-021 SCAN output transfer with out_lst=0: clear the emitted bit in mask, stay SCAN.
REQ-022 SCAN output transfer with out_lst=1: mask<=0, go IDLE, unless the next input is accepted in the same cycle.
REQ-023 in_rdy SHALL be 1 in SCAN/ZERO only in the cycle where the last beat transfers (out_vld&out_rdy&out_lst); an input accepted then SHALL load per REQ-017 with no bubble, giving one output beat per cycle across vectors.
REQ-024 ZERO: out_vld=1, out_emp=1, out_lst=1, out_idx=0; on transfer go IDLE (or reload per REQ-023).
REQ-025 While out_vld=1 and out_rdy=0, out_idx, out_lst, out_emp and mask SHALL hold stable.
REQ-026 An input vector with all WIDTH bits set SHALL produce WIDTH beats, indices strictly monotonic in the selected order.
REQ-027 When WIDTH is not a power of two, out_idx SHALL never exceed WIDTH-1.
REQ-028 Output fields SHALL be driven from registered state only (no combinational path from in_dat to outputs).

Reset
REQ-029 On rising clk with rst=1: state<=IDLE, mask<=0; outputs after that edge: out_vld=0, out_lst=0, out_emp=0, out_idx=0.
REQ-030 in_rdy SHALL be 0 while rst=1; no input transfer occurs in a reset cycle.
REQ-031 Reset mid-operation (SCAN or ZERO, stalled or not) SHALL abandon the vector; no further beats for it.

Verification (WIDTH=16, SPLIT=4)
REQ-032 MSB_FIRST=0, in_dat=16'h8421, out_rdy=1 -> beats idx 0,5,10,15 on cycles +1..+4, out_lst only on idx 15, in_rdy=0 on cycles +1..+3.
REQ-033 MSB_FIRST=1, in_dat=16'h8421 -> beats idx 15,10,5,0; out_lst on idx 0.
REQ-034 in_dat=16'h0000 -> single beat out_emp=1, out_lst=1, out_idx=0 one cycle later.
REQ-035 Back-to-back: in_vld held with 16'h0003 then 16'h8000, out_rdy=1 -> beats 0,1,15 on consecutive cycles, second vector accepted on the idx-1 beat cycle.
REQ-036 Backpressure: in_dat=16'h0006, out_rdy low 3 cycles after first beat -> idx=1 held stable 4 cycles, then idx=2 with out_lst=1.
REQ-037 Assert rst during SCAN of 16'hFFFF after 5 beats -> out_vld=0 next cycle, in_rdy=1 after rst release, next vector 16'h0010 yields single beat idx=4, out_lst=1.
